// File: rtl/collision_pkg.sv
// Shared constants and types for the collision event scheduler.
package collision_pkg;

  localparam int NUM_SRC_DEF = 8;

  // Collision source indices (bit positions in collision_src)
  localparam int SRC_PLAYER_WALL      = 0;
  localparam int SRC_PLAYER_BRICK     = 1;
  localparam int SRC_PLAYER_EXPLOSION = 2;
  localparam int SRC_PLAYER_ENEMY     = 3;
  localparam int SRC_BOMB_BRICK       = 4;
  localparam int SRC_ENEMY_EXPLOSION  = 5;
  localparam int SRC_PLAYER_POWERUP   = 6;
  localparam int SRC_BOMB_WALL        = 7;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} sched_state_t;

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational encoder: index of the lowest set bit, plus a found flag.
module lsb_priority_encoder #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = i[IW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/collision_event_scheduler.sv
// Records each collision source at most once per frame, then at start of
// frame hands the recorded set to game logic one event per handshake,
// lowest index first.
module collision_event_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int IDW     = $clog2(NUM_SRC),
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [NUM_SRC-1:0] collision_src,
  input  logic [NUM_SRC-1:0] src_enable,
  input  logic               event_ready,
  output logic               event_valid,
  output logic [IDW-1:0]     event_id,
  output logic [NUM_SRC-1:0] frame_hit_mask,
  output logic               overrun,
  output logic [CNTW-1:0]    event_count,
  output logic               busy
);

  sched_state_t       state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, drain_q, drain_d;
  logic [NUM_SRC-1:0] snap, clr, survive;
  logic               xfer, overrun_d, found_unused;

  lsb_priority_encoder #(.N(NUM_SRC), .IW(IDW)) u_enc (
    .vec   (drain_q),
    .idx   (event_id),
    .found (found_unused)
  );

  assign event_valid = (state_q == DRAIN);
  assign busy        = event_valid;
  assign xfer        = event_valid & event_ready;
  // Strobes in the startOfFrame cycle still belong to the ending frame
  assign snap        = pending_q | (collision_src & src_enable);
  assign clr         = xfer ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << event_id) : '0;
  assign survive     = drain_q & ~clr;

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, next drain set and overrun detection
  always_comb begin
    state_d   = state_q;
    drain_d   = survive;
    overrun_d = 1'b0;
    if (startOfFrame) begin
      drain_d   = snap;
      overrun_d = (state_q == DRAIN) && (survive != '0);
      state_d   = (snap != '0) ? DRAIN : IDLE;
    end else if (state_q == DRAIN && survive == '0) begin
      state_d = IDLE;
    end
  end

  // Accumulation, snapshot, overrun pulse and delivered-event counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pending_q      <= '0;
      drain_q        <= '0;
      frame_hit_mask <= '0;
      overrun        <= 1'b0;
      event_count    <= '0;
    end else begin
      drain_q <= drain_d;
      overrun <= overrun_d;
      if (startOfFrame) begin
        pending_q      <= '0;
        frame_hit_mask <= snap;
      end else begin
        pending_q <= snap;
      end
      if (xfer && event_count != {CNTW{1'b1}})
        event_count <= event_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Directed bench for collision_event_scheduler: inputs change 1 ns after
// each rising edge, outputs are checked at the same point.
module tb_collision_event_scheduler;
  import collision_pkg::*;

  localparam int NUM_SRC = 8;
  localparam int IDW     = 3;
  localparam int CNTW    = 16;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic [NUM_SRC-1:0] collision_src;
  logic [NUM_SRC-1:0] src_enable;
  logic               event_ready;
  logic               event_valid;
  logic [IDW-1:0]     event_id;
  logic [NUM_SRC-1:0] frame_hit_mask;
  logic               overrun;
  logic [CNTW-1:0]    event_count;
  logic               busy;

  int errors = 0;
  int checks = 0;

  collision_event_scheduler #(.NUM_SRC(NUM_SRC), .IDW(IDW), .CNTW(CNTW)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .startOfFrame   (startOfFrame),
    .collision_src  (collision_src),
    .src_enable     (src_enable),
    .event_ready    (event_ready),
    .event_valid    (event_valid),
    .event_id       (event_id),
    .frame_hit_mask (frame_hit_mask),
    .overrun        (overrun),
    .event_count    (event_count),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse(input logic [NUM_SRC-1:0] edge_src);
    collision_src = edge_src;
    startOfFrame  = 1'b1;
    tick();
    startOfFrame  = 1'b0;
    collision_src = '0;
  endtask

  task automatic test_reset();
    resetN = 1'b0; startOfFrame = 1'b0; collision_src = '0;
    src_enable = '1; event_ready = 1'b0;
    #12;
    checks++;
    if ({event_valid, event_id, frame_hit_mask, overrun, event_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state: got v=%b id=%0d mask=%h ovr=%b cnt=%0d busy=%b, want all 0",
               event_valid, event_id, frame_hit_mask, overrun, event_count, busy);
    end
    resetN = 1'b1;
    tick();
  endtask

  task automatic test_multi_hit();
    collision_src = 8'h04;
    for (int i = 0; i < 500; i++) tick();
    sof_pulse('0);
    checks++;
    if (event_valid !== 1'b1 || event_id !== 3'd2 || frame_hit_mask !== 8'b0000_0100) begin
      errors++;
      $display("FAIL multi_hit_present: got v=%b id=%0d mask=%b, want v=1 id=2 mask=00000100",
               event_valid, event_id, frame_hit_mask);
    end
    event_ready = 1'b1;
    tick();
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd1) begin
      errors++;
      $display("FAIL multi_hit_once: got v=%b cnt=%0d, want v=0 cnt=1", event_valid, event_count);
    end
    event_ready = 1'b0;
  endtask

  task automatic test_priority();
    logic [IDW-1:0] exp_ids [3];
    exp_ids[0] = 3'd1; exp_ids[1] = 3'd5; exp_ids[2] = 3'd7;
    collision_src = 8'hA2;
    tick();
    collision_src = '0;
    event_ready = 1'b1;
    sof_pulse('0);
    checks++;
    if (frame_hit_mask !== 8'hA2) begin
      errors++;
      $display("FAIL priority_mask: got %h, want a2", frame_hit_mask);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (event_valid !== 1'b1 || busy !== 1'b1 || event_id !== exp_ids[i]) begin
        errors++;
        $display("FAIL priority_seq%0d: got v=%b busy=%b id=%0d, want v=1 busy=1 id=%0d",
                 i, event_valid, busy, event_id, exp_ids[i]);
      end
      tick();
    end
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd4) begin
      errors++;
      $display("FAIL priority_done: got v=%b cnt=%0d, want v=0 cnt=4", event_valid, event_count);
    end
    event_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    collision_src = 8'h0A;
    tick();
    collision_src = '0;
    sof_pulse('0);
    for (int i = 0; i < 10; i++) begin
      if (event_valid !== 1'b1 || event_id !== 3'd1) bad++;
      tick();
    end
    checks++;
    if (bad != 0 || event_count !== 16'd4) begin
      errors++;
      $display("FAIL backpressure_hold: unstable cycles=%0d cnt=%0d, want 0 unstable cnt=4",
               bad, event_count);
    end
    event_ready = 1'b1;
    tick();
    checks++;
    if (event_valid !== 1'b1 || event_id !== 3'd3 || event_count !== 16'd5) begin
      errors++;
      $display("FAIL backpressure_first: got v=%b id=%0d cnt=%0d, want v=1 id=3 cnt=5",
               event_valid, event_id, event_count);
    end
    tick();
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd6) begin
      errors++;
      $display("FAIL backpressure_done: got v=%b cnt=%0d, want v=0 cnt=6", event_valid, event_count);
    end
    event_ready = 1'b0;
  endtask

  task automatic test_overrun();
    collision_src = 8'h49;
    tick();
    collision_src = '0;
    sof_pulse('0);
    checks++;
    if (event_valid !== 1'b1 || event_id !== 3'd0) begin
      errors++;
      $display("FAIL overrun_setup: got v=%b id=%0d, want v=1 id=0", event_valid, event_id);
    end
    collision_src = 8'h10;
    tick();
    sof_pulse('0);
    checks++;
    if (overrun !== 1'b1 || event_id !== 3'd4 || frame_hit_mask !== 8'h10 || event_count !== 16'd6) begin
      errors++;
      $display("FAIL overrun_pulse: got ovr=%b id=%0d mask=%h cnt=%0d, want ovr=1 id=4 mask=10 cnt=6",
               overrun, event_id, frame_hit_mask, event_count);
    end
    tick();
    checks++;
    if (overrun !== 1'b0 || event_id !== 3'd4 || event_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_one_cycle: got ovr=%b v=%b id=%0d, want ovr=0 v=1 id=4",
               overrun, event_valid, event_id);
    end
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd7) begin
      errors++;
      $display("FAIL overrun_only_new: got v=%b cnt=%0d, want v=0 cnt=7", event_valid, event_count);
    end
    // last bit transferred on the startOfFrame edge: no overrun
    collision_src = 8'h04;
    tick();
    collision_src = '0;
    sof_pulse('0);
    collision_src = 8'h20;
    tick();
    event_ready = 1'b1;
    sof_pulse('0);
    checks++;
    if (overrun !== 1'b0 || event_count !== 16'd8 || event_valid !== 1'b1 || event_id !== 3'd5) begin
      errors++;
      $display("FAIL overrun_coincident: got ovr=%b cnt=%0d v=%b id=%0d, want ovr=0 cnt=8 v=1 id=5",
               overrun, event_count, event_valid, event_id);
    end
    tick();
    event_ready = 1'b0;
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd9) begin
      errors++;
      $display("FAIL overrun_coincident_done: got v=%b cnt=%0d, want v=0 cnt=9", event_valid, event_count);
    end
  endtask

  task automatic test_mask_edge();
    src_enable = 8'hF7;
    collision_src = 8'h08;
    for (int i = 0; i < 4; i++) tick();
    sof_pulse(8'h48);
    checks++;
    if (frame_hit_mask !== 8'h40 || event_valid !== 1'b1 || event_id !== 3'd6) begin
      errors++;
      $display("FAIL mask_edge: got mask=%h v=%b id=%0d, want mask=40 v=1 id=6",
               frame_hit_mask, event_valid, event_id);
    end
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd10) begin
      errors++;
      $display("FAIL mask_single: got v=%b cnt=%0d, want v=0 cnt=10", event_valid, event_count);
    end
    sof_pulse('0);
    checks++;
    if (frame_hit_mask !== 8'h00 || event_valid !== 1'b0) begin
      errors++;
      $display("FAIL mask_no_carry: got mask=%h v=%b, want mask=00 v=0", frame_hit_mask, event_valid);
    end
    src_enable = '1;
  endtask

  task automatic test_reset_mid_drain();
    collision_src = 8'h0E;
    tick();
    collision_src = '0;
    sof_pulse('0);
    checks++;
    if (event_valid !== 1'b1 || event_id !== 3'd1) begin
      errors++;
      $display("FAIL rst_mid_setup: got v=%b id=%0d, want v=1 id=1", event_valid, event_id);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if ({event_valid, event_id, frame_hit_mask, overrun, event_count, busy} !== '0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b id=%0d mask=%h ovr=%b cnt=%0d, want all 0",
               event_valid, event_id, frame_hit_mask, overrun, event_count);
    end
    tick();
    resetN = 1'b1;
    tick();
    sof_pulse('0);
    checks++;
    if (event_valid !== 1'b0 || frame_hit_mask !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_after: got v=%b mask=%h, want v=0 mask=00", event_valid, frame_hit_mask);
    end
    tick();
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_idle: got v=%b cnt=%0d, want v=0 cnt=0", event_valid, event_count);
    end
  endtask

  initial begin
    test_reset();
    test_multi_hit();
    test_priority();
    test_backpressure();
    test_overrun();
    test_mask_edge();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
